// File: rtl/intr_cause_ctrl.sv
// Exception/interrupt controller: arbitrates EX-stage exception sources,
// drives the Cause/EPC register write ports and redirects fetch to the
// handler, then back to EPC on ERET.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | normal execution, watching for an event in EX
// TAKE    | one cycle: write Cause/EPC, flush, fetch handler
// HANDLER | servicing; exceptions ignored, waiting for ERET
// RET     | one cycle: flush, fetch from EPC
module intr_cause_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        ovf_exc,
  input  logic        ri_exc,
  input  logic        sys_exc,
  input  logic        eret,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic [31:0] ex_pc,
  input  logic [31:0] epc_in,
  output logic [31:0] cause_data,
  output logic        cause_write,
  output logic [31:0] epc_data,
  output logic        epc_write,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        in_handler
);

  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_HANDLER, S_RET} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_irq_d;
  logic                   r_irq_pending;
  logic [1:0]             r_code;
  logic [1:0]             w_code;
  logic                   w_irq_s, w_rise, w_ev, w_take;

  logic [31:0] r_cause_data, w_cause_data;
  logic        r_cause_write, w_cause_write;
  logic [31:0] r_epc_data, w_epc_data;
  logic        r_epc_write, w_epc_write;
  logic        r_flush, w_flush;
  logic        r_redirect, w_redirect;
  logic [31:0] r_redirect_pc, w_redirect_pc;
  logic        r_in_handler, w_in_handler;

  assign w_irq_s = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_irq_s & ~r_irq_d;
  assign w_ev    = ex_valid & ~stall;
  assign w_take  = w_ev & (ovf_exc | ri_exc | sys_exc | r_irq_pending);

  // Fixed-priority source encode: ovf > ri > sys > pending irq.
  always_comb begin
    w_code = 2'b00;
    if (ovf_exc)      w_code = 2'b01;
    else if (ri_exc)  w_code = 2'b10;
    else if (sys_exc) w_code = 2'b11;
  end

  // Synchronize ext_irq and keep one merged pending request per rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync        <= '0;
      r_irq_d       <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], ext_irq};
      r_irq_d <= w_irq_s;
      // Clearing happens as the interrupt is taken; a fresh edge in that
      // same cycle is a new request and survives the clear.
      if (r_state == S_TAKE && r_code == 2'b00)
        r_irq_pending <= w_rise;
      else
        r_irq_pending <= r_irq_pending | w_rise;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_cause_data  = '0;
    w_cause_write = 1'b0;
    w_epc_data    = '0;
    w_epc_write   = 1'b0;
    w_flush       = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_in_handler  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt   = S_TAKE;
          w_cause_data  = {28'b0, w_code, 2'b00};
          w_cause_write = 1'b1;
          // syscall returns past itself; faults and irqs re-execute
          w_epc_data    = (w_code == 2'b11) ? ex_pc + 32'd4 : ex_pc;
          w_epc_write   = 1'b1;
          w_flush       = 1'b1;
          w_redirect    = 1'b1;
          w_redirect_pc = HANDLER_ADDR;
          w_in_handler  = 1'b1;
        end
      end
      S_TAKE: begin
        w_state_nxt  = S_HANDLER;
        w_in_handler = 1'b1;
      end
      S_HANDLER: begin
        w_in_handler = 1'b1;
        if (w_ev && eret) begin
          w_state_nxt   = S_RET;
          w_flush       = 1'b1;
          w_redirect    = 1'b1;
          w_redirect_pc = epc_in;
        end
      end
      S_RET: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched code and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_code        <= 2'b00;
      r_cause_data  <= '0;
      r_cause_write <= 1'b0;
      r_epc_data    <= '0;
      r_epc_write   <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_in_handler  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      if (r_state == S_IDLE && w_take) r_code <= w_code;
      r_cause_data  <= w_cause_data;
      r_cause_write <= w_cause_write;
      r_epc_data    <= w_epc_data;
      r_epc_write   <= w_epc_write;
      r_flush       <= w_flush;
      r_redirect    <= w_redirect;
      r_redirect_pc <= w_redirect_pc;
      r_in_handler  <= w_in_handler;
    end
  end

  assign cause_data  = r_cause_data;
  assign cause_write = r_cause_write;
  assign epc_data    = r_epc_data;
  assign epc_write   = r_epc_write;
  assign flush       = r_flush;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign in_handler  = r_in_handler;

endmodule

// File: tb/tb_intr_cause_ctrl.sv
// Bench for intr_cause_ctrl: directed scenarios plus random traffic, all
// compared against a cycle-level behavioural model of the controller.
module tb_intr_cause_ctrl;
  localparam logic [31:0] HADDR = 32'h0000_0008;
  localparam int          S     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, ovf_exc, ri_exc, sys_exc, eret, ex_valid, stall;
  logic [31:0] ex_pc, epc_in;
  logic [31:0] cause_data, epc_data, redirect_pc;
  logic        cause_write, epc_write, flush, redirect, in_handler;

  always #5 clk = ~clk;

  intr_cause_ctrl #(.HANDLER_ADDR(HADDR), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .ovf_exc(ovf_exc),
    .ri_exc(ri_exc), .sys_exc(sys_exc), .eret(eret), .ex_valid(ex_valid),
    .stall(stall), .ex_pc(ex_pc), .epc_in(epc_in),
    .cause_data(cause_data), .cause_write(cause_write),
    .epc_data(epc_data), .epc_write(epc_write), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .in_handler(in_handler)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: mode 0 running, 1 taking, 2 in handler, 3 returning.
  int          m_mode;
  int          m_code;
  bit          m_pend;
  bit          xh [0:7];
  logic [31:0] e_cause, e_epc, e_rpc;
  logic        e_cw, e_ew, e_fl, e_rd, e_ih;

  function automatic logic [127:0] outvec();
    return {27'b0, cause_data, cause_write, epc_data, epc_write,
            flush, redirect, redirect_pc, in_handler};
  endfunction

  function automatic logic [127:0] expvec();
    return {27'b0, e_cause, e_cw, e_epc, e_ew, e_fl, e_rd, e_rpc, e_ih};
  endfunction

  task automatic model_clear_exp();
    e_cause = '0; e_epc = '0; e_rpc = '0;
    e_cw = 0; e_ew = 0; e_fl = 0; e_rd = 0; e_ih = 0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_code = 0; m_pend = 0;
    for (int i = 0; i < 8; i++) xh[i] = 0;
    model_clear_exp();
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit ev, rise;
    ev = ex_valid && !stall;
    for (int i = 7; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = ext_irq;
    // a level change becomes an arbitrable request S+1 edges after sampling
    rise = xh[S] && !xh[S+1];
    model_clear_exp();
    case (m_mode)
      0: begin
        if (ev && (ovf_exc || ri_exc || sys_exc || m_pend)) begin
          m_code  = ovf_exc ? 1 : ri_exc ? 2 : sys_exc ? 3 : 0;
          e_cause = 32'(m_code * 4);
          e_epc   = (m_code == 3) ? ex_pc + 32'd4 : ex_pc;
          e_cw = 1; e_ew = 1; e_fl = 1; e_rd = 1; e_rpc = HADDR; e_ih = 1;
          m_mode  = 1;
        end
        m_pend = m_pend || rise;
      end
      1: begin
        m_pend = (m_code == 0) ? rise : (m_pend || rise);
        e_ih   = 1;
        m_mode = 2;
      end
      2: begin
        e_ih = 1;
        if (ev && eret) begin
          e_fl = 1; e_rd = 1; e_rpc = epc_in;
          m_mode = 3;
        end
        m_pend = m_pend || rise;
      end
      default: begin
        m_mode = 0;
        m_pend = m_pend || rise;
      end
    endcase
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk(tag, outvec(), expvec());
  endtask

  task automatic idle_in();
    ovf_exc = 0; ri_exc = 0; sys_exc = 0; eret = 0;
    ex_valid = 0; stall = 0; ex_pc = '0; epc_in = '0;
  endtask

  task automatic leave_handler(input logic [31:0] a);
    idle_in();
    step("handler_wait");
    eret = 1; ex_valid = 1; epc_in = a;
    step("eret");
    chk("ret_redirect_pc", {96'b0, redirect_pc}, {96'b0, a});
    chk("ret_redirect", {127'b0, redirect}, 128'd1);
    idle_in();
    step("ret_exit");
  endtask

  bit seen;

  initial begin
    rst = 1; ext_irq = 0; idle_in(); model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_outs", outvec(), 128'd0);

    // overflow
    ovf_exc = 1; ex_valid = 1; ex_pc = 32'h40;
    step("ovf_take");
    chk("ovf_cause", {96'b0, cause_data}, 128'h4);
    chk("ovf_epc", {96'b0, epc_data}, 128'h40);
    chk("ovf_strobes", {124'b0, cause_write, epc_write, flush, redirect}, 128'hF);
    chk("ovf_rpc", {96'b0, redirect_pc}, 128'h8);
    idle_in();
    step("ovf_after");
    chk("ovf_one_cycle", {124'b0, cause_write, epc_write, flush, redirect}, 128'h0);
    chk("ovf_in_handler", {127'b0, in_handler}, 128'd1);
    leave_handler(32'h40);

    // priority
    ovf_exc = 1; ri_exc = 1; sys_exc = 1; ex_valid = 1; ex_pc = 32'h80;
    step("prio_take");
    chk("prio_cause", {96'b0, cause_data}, 128'h4);
    leave_handler(32'h80);

    // syscall
    sys_exc = 1; ex_valid = 1; ex_pc = 32'h100;
    step("sys_take");
    chk("sys_cause", {96'b0, cause_data}, 128'hC);
    chk("sys_epc", {96'b0, epc_data}, 128'h104);
    leave_handler(32'h104);

    // stall gating
    sys_exc = 1; ex_valid = 1; stall = 1; ex_pc = 32'h120;
    seen = 0;
    repeat (3) begin step("stall_hold"); seen |= cause_write; end
    chk("stall_no_take", {127'b0, seen}, 128'd0);
    stall = 0;
    step("stall_release");
    chk("stall_take", {127'b0, cause_write}, 128'd1);
    leave_handler(32'h124);

    // bubble gating
    sys_exc = 1; ex_valid = 0; seen = 0;
    repeat (5) begin step("bubble"); seen |= cause_write; end
    chk("bubble_no_take", {127'b0, seen}, 128'd0);

    // deferred interrupt
    idle_in(); sys_exc = 1; ex_valid = 1; ex_pc = 32'h300;
    step("irq_pre_take");
    idle_in();
    step("irq_pre_handler");
    ext_irq = 1; seen = 0;
    repeat (5) begin step("irq_in_handler"); seen |= cause_write | epc_write; end
    chk("irq_deferred", {127'b0, seen}, 128'd0);
    eret = 1; ex_valid = 1; epc_in = 32'h200;
    step("irq_eret");
    chk("irq_ret_pc", {96'b0, redirect_pc}, 128'h200);
    idle_in();
    step("irq_ret_exit");
    ex_valid = 1; ex_pc = 32'h200;
    step("irq_take");
    chk("irq_cause", {96'b0, cause_data}, 128'h0);
    chk("irq_epc", {96'b0, epc_data}, 128'h200);
    chk("irq_cw", {127'b0, cause_write}, 128'd1);
    ext_irq = 0;
    leave_handler(32'h200);

    // eret in IDLE
    eret = 1; ex_valid = 1; epc_in = 32'h500;
    step("eret_idle");
    chk("eret_idle_redirect", {127'b0, redirect}, 128'd0);

    // wrap and ovf in HANDLER
    idle_in(); sys_exc = 1; ex_valid = 1; ex_pc = 32'hFFFF_FFFC;
    step("wrap_take");
    chk("wrap_epc", {96'b0, epc_data}, 128'h0);
    idle_in();
    step("wrap_handler");
    ovf_exc = 1; ex_valid = 1;
    step("ovf_in_handler");
    chk("ovf_handler_no_cw", {127'b0, cause_write}, 128'd0);
    leave_handler(32'h0);

    // async reset mid-TAKE
    sys_exc = 1; ex_valid = 1; ex_pc = 32'h600;
    step("rst_take");
    #2 rst = 1;
    #1 chk("rst_async", outvec(), 128'd0);
    idle_in(); model_reset();
    @(posedge clk);
    #1 rst = 0;
    seen = 0;
    repeat (4) begin step("rst_after"); seen |= cause_write; end
    chk("rst_no_trailing", {127'b0, seen}, 128'd0);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      ovf_exc  = ($urandom_range(0, 15) == 0);
      ri_exc   = ($urandom_range(0, 15) == 0);
      sys_exc  = ($urandom_range(0, 11) == 0);
      eret     = ($urandom_range(0, 3) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      ex_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      epc_in   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 12) == 0) ext_irq = ~ext_irq;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/intr_cause_ctrl.md
Name: intr_cause_ctrl

Overview:
- Exception/interrupt controller for the pipelined CPU. It is the writer side of the Cause and EPC registers.
- Samples exception sources at the EX stage and arbitrates them by priority.
- Produces the Cause word (ExcCode in [3:2]) plus its write strobe, and the EPC value plus its write strobe.
- Flushes the pipeline, redirects fetch to the handler, and on ERET returns to the address held in EPC.

Parameters:
- HANDLER_ADDR, 32'h0000_0008, fetch address of the common exception handler.
- SYNC_STAGES, 2, flip-flop depth of the ext_irq synchronizer (legal values 2–3).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ext_irq  in  1  external interrupt, asynchronous level
- ovf_exc  in  1  arithmetic overflow flagged by the instruction in EX
- ri_exc  in  1  reserved instruction flagged for the instruction in EX
- sys_exc  in  1  syscall in EX
- eret  in  1  ERET in EX
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- stall  in  1  pipeline stalled; EX contents held
- ex_pc  in  32  PC of the instruction in EX
- epc_in  in  32  current EPC register output
- cause_data  out  32  value for the Cause register
- cause_write  out  1  Cause write strobe
- epc_data  out  32  value for the EPC register
- epc_write  out  1  EPC write strobe
- flush  out  1  kill IF/ID/EX/MEM contents this cycle
- redirect  out  1  load redirect_pc into the PC
- redirect_pc  out  32  target fetch address
- in_handler  out  1  high while servicing (interrupts disabled)

Behaviour:
- All outputs are registered. Reset value of every output is 0; state goes to IDLE; irq_pending and the synchronizer are cleared.
- Reset mid-operation (in any state) aborts immediately, with no trailing strobes.
- ExcCode encoding: 00 ext interrupt, 01 overflow, 10 reserved instruction, 11 syscall.
- cause_data = {28'b0, code, 2'b00}.
- ext_irq path: it passes through SYNC_STAGES flops. A rising edge of the synchronized signal sets irq_pending, which is cleared only when the interrupt is taken. Edges while irq_pending is already set merge into the one pending request.
- "Event" means the condition is evaluated in cycle N with ex_valid=1 and stall=0. Priority: ovf > ri > sys > irq_pending.
- States:
  - IDLE: on an event, latch code and EPC value and go to TAKE. Sources with ex_valid=0 or stall=1 are ignored, except that irq_pending stays pending. eret in IDLE is ignored.
  - TAKE (exactly 1 cycle, N+1):
    - cause_write=1, epc_write=1, flush=1, redirect=1, redirect_pc=HANDLER_ADDR.
    - EPC value: ex_pc for ovf, ri and irq (faulting or interrupted instruction is re-executed/reported); ex_pc+4 for sys.
    - Clear irq_pending if code=00.
    - Go to HANDLER.
  - HANDLER: in_handler=1, and it stays 1 through TAKE, HANDLER and RET.
    - ovf/ri/sys are ignored; new irq edges set irq_pending.
    - eret with ex_valid=1 and stall=0 goes to RET. eret wins over any simultaneous source.
  - RET (exactly 1 cycle): flush=1, redirect=1, redirect_pc=epc_in sampled on entry to RET. Next state is IDLE.
- A pending irq is taken on the first IDLE cycle with a valid, unstalled instruction in EX. There is no nesting.
- Strobes are single-cycle pulses and are never asserted in IDLE or HANDLER.
- ex_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Test Plan:
- Reset: rst pulsed mid-TAKE → all outputs 0 in the same cycle; idle after release; no cause_write ever seen.
- Overflow: ovf_exc=1, ex_pc=32'h0000_0040, ex_valid=1 → next cycle cause_data=32'h4, epc_data=32'h40, cause_write=epc_write=flush=redirect=1, redirect_pc=32'h8, each for one cycle.
- Priority and syscall:
  - ovf, ri and sys all high → cause_data=32'h4.
  - sys alone at ex_pc=32'h100 → cause_data=32'hC, epc_data=32'h104.
- Gating: sys_exc=1 with stall=1 for 3 cycles, then stall=0 → take occurs exactly one cycle after stall drops. With ex_valid=0 → never taken.
- Deferred interrupt: ext_irq rises while in HANDLER → no strobes. eret with epc_in=32'h200 → RET redirect_pc=32'h200. First valid IDLE instruction at ex_pc=32'h200 → cause_data=32'h0, epc_data=32'h200.
- Edge cases:
  - eret in IDLE → no redirect.
  - ovf in HANDLER → no Cause write.
  - sys at ex_pc=32'hFFFF_FFFC → epc_data=32'h0.
